// File: rtl/hdlc_bus_sched_if.sv
// Handshake and core-register bus bundle for hdlc_bus_sched.
// master: the scheduler's view; slave: the frame source/sink plus the HDLC core.
interface hdlc_bus_sched_if;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_byte;
  logic          tx_last;
  logic          tx_done;
  logic          tx_err;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] rx_byte;
  logic          rx_last;
  logic          rx_err;
  logic          Rx_Ready;
  logic [AW-1:0] Address;
  logic          WriteEnable;
  logic          ReadEnable;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;

  modport master (
    input  tx_valid, tx_byte, tx_last, rx_ready, Rx_Ready, DataOut,
    output tx_ready, tx_done, tx_err, rx_valid, rx_byte, rx_last, rx_err,
           Address, WriteEnable, ReadEnable, DataIn
  );

  modport slave (
    output tx_valid, tx_byte, tx_last, rx_ready, Rx_Ready, DataOut,
    input  tx_ready, tx_done, tx_err, rx_valid, rx_byte, rx_last, rx_err,
           Address, WriteEnable, ReadEnable, DataIn
  );
endinterface

// File: rtl/hdlc_bus_sched.sv
// Sole master of the HDLC core register bus: loads/starts Tx frames and drains Rx frames.
// Define HDLC_BUS_SCHED_WDOG_EN to abort a transmission whose Tx_Done never arrives.
module hdlc_bus_sched #(
  parameter int unsigned TX_MAX_LEN = 126,
  parameter int unsigned TX_TIMEOUT = 4096
) (
  input logic              Clk,
  input logic              Rst,
  hdlc_bus_sched_if.master bus
);
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned TXCW = 7;
  localparam int unsigned RXCW = 8;

  localparam logic [AW-1:0] A_TX_SC   = AW'(0);
  localparam logic [AW-1:0] A_TX_BUFF = AW'(1);
  localparam logic [AW-1:0] A_RX_SC   = AW'(2);
  localparam logic [AW-1:0] A_RX_BUFF = AW'(3);
  localparam logic [AW-1:0] A_RX_LEN  = AW'(4);

  typedef enum logic [3:0] {
    IDLE, TX_CHK, TX_LOAD, TX_WR, TX_START, TX_POLL,
    RX_SC, RX_LEN, RX_RD, RX_OUT, RX_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            we_q, we_d, re_q, re_d;
  logic            tx_ready_q, tx_ready_d, tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic            rx_valid_q, rx_valid_d, rx_last_q, rx_last_d, rx_err_q, rx_err_d;
  logic [DW-1:0]   rx_byte_q, rx_byte_d;
  logic            tx_busy_q, tx_busy_d, last_grant_tx_q, last_grant_tx_d;
  logic            tx_trunc_q, tx_trunc_d, tx_fin_q, tx_fin_d;
  logic [TXCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RXCW-1:0] rx_len_q, rx_len_d, rx_cnt_q, rx_cnt_d;
  logic            tx_room;

`ifdef HDLC_BUS_SCHED_WDOG_EN
  localparam int unsigned WDW = 16;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_exp;
  assign wd_exp = (wd_cnt_q == WDW'(TX_TIMEOUT));
  assign wd_cnt_d = !tx_busy_q ? '0 : (wd_exp ? wd_cnt_q : wd_cnt_q + WDW'(1));
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) wd_cnt_q <= '0;
    else      wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TX_TIMEOUT);
`endif

  assign tx_room = (tx_cnt_q < TXCW'(TX_MAX_LEN));

  // Reads: the predecessor raises ReadEnable on entry; the state samples DataOut once re_q drops.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    din_d           = din_q;
    we_d            = 1'b0;
    re_d            = 1'b0;
    tx_ready_d      = tx_ready_q;
    tx_done_d       = 1'b0;
    tx_err_d        = 1'b0;
    rx_valid_d      = rx_valid_q;
    rx_last_d       = rx_last_q;
    rx_byte_d       = rx_byte_q;
    rx_err_d        = 1'b0;
    tx_busy_d       = tx_busy_q;
    last_grant_tx_d = last_grant_tx_q;
    tx_trunc_d      = tx_trunc_q;
    tx_fin_d        = tx_fin_q;
    tx_cnt_d        = tx_cnt_q;
    rx_len_d        = rx_len_q;
    rx_cnt_d        = rx_cnt_q;

    case (state_q)
      IDLE: begin
        // a write still in flight may clear Rx_Ready, so hold off one cycle
        if (we_q) begin
          state_d = IDLE;
        end
`ifdef HDLC_BUS_SCHED_WDOG_EN
        else if (tx_busy_q && wd_exp) begin
          we_d      = 1'b1;
          addr_d    = A_TX_SC;
          din_d     = DW'(8'h04);
          tx_busy_d = 1'b0;
          tx_err_d  = 1'b1;
        end
`endif
        else if (tx_busy_q) begin
          re_d    = 1'b1;
          addr_d  = bus.Rx_Ready ? A_RX_SC : A_TX_SC;
          state_d = bus.Rx_Ready ? RX_SC : TX_POLL;
        end else if (bus.Rx_Ready && (!bus.tx_valid || last_grant_tx_q)) begin
          re_d            = 1'b1;
          addr_d          = A_RX_SC;
          last_grant_tx_d = 1'b0;
          state_d         = RX_SC;
        end else if (bus.tx_valid) begin
          re_d            = 1'b1;
          addr_d          = A_TX_SC;
          last_grant_tx_d = 1'b1;
          state_d         = TX_CHK;
        end
      end
      TX_CHK: begin
        if (!re_q) begin
          if (bus.DataOut[0]) begin
            tx_ready_d = 1'b1;
            tx_cnt_d   = '0;
            tx_trunc_d = 1'b0;
            state_d    = TX_LOAD;
          end else begin
            re_d   = 1'b1;
            addr_d = A_TX_SC;
          end
        end
      end
      TX_LOAD: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_ready_d = 1'b0;
          tx_fin_d   = bus.tx_last;
          state_d    = TX_WR;
          if (tx_room) begin
            we_d     = 1'b1;
            addr_d   = A_TX_BUFF;
            din_d    = bus.tx_byte;
            tx_cnt_d = tx_cnt_q + TXCW'(1);
          end else begin
            tx_trunc_d = 1'b1;
          end
          tx_err_d = bus.tx_last && (tx_trunc_q || !tx_room);
        end
      end
      TX_WR: begin
        if (tx_fin_q) begin
          state_d = TX_START;
        end else begin
          tx_ready_d = 1'b1;
          state_d    = TX_LOAD;
        end
      end
      TX_START: begin
        we_d      = 1'b1;
        addr_d    = A_TX_SC;
        din_d     = DW'(8'h02);
        tx_busy_d = 1'b1;
        state_d   = IDLE;
      end
      TX_POLL: begin
        if (!re_q) begin
          if (bus.DataOut[0]) begin
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      RX_SC: begin
        if (!re_q) begin
          if (|bus.DataOut[4:2]) begin
            state_d = RX_DROP;
          end else begin
            re_d    = 1'b1;
            addr_d  = A_RX_LEN;
            state_d = RX_LEN;
          end
        end
      end
      RX_LEN: begin
        if (!re_q) begin
          if (bus.DataOut == '0) begin
            state_d = RX_DROP;
          end else begin
            rx_len_d = bus.DataOut;
            rx_cnt_d = '0;
            re_d     = 1'b1;
            addr_d   = A_RX_BUFF;
            state_d  = RX_RD;
          end
        end
      end
      RX_RD: begin
        if (!re_q) begin
          rx_byte_d  = bus.DataOut;
          rx_valid_d = 1'b1;
          rx_cnt_d   = rx_cnt_q + RXCW'(1);
          rx_last_d  = ((rx_cnt_q + RXCW'(1)) == rx_len_q);
          state_d    = RX_OUT;
        end
      end
      RX_OUT: begin
        if (bus.rx_ready && rx_valid_q) begin
          rx_valid_d = 1'b0;
          rx_last_d  = 1'b0;
          if (rx_last_q) begin
            state_d = IDLE;
          end else begin
            re_d    = 1'b1;
            addr_d  = A_RX_BUFF;
            state_d = RX_RD;
          end
        end
      end
      RX_DROP: begin
        we_d     = 1'b1;
        addr_d   = A_RX_SC;
        din_d    = DW'(8'h02);
        rx_err_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      din_q           <= '0;
      we_q            <= 1'b0;
      re_q            <= 1'b0;
      tx_ready_q      <= 1'b0;
      tx_done_q       <= 1'b0;
      tx_err_q        <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_last_q       <= 1'b0;
      rx_byte_q       <= '0;
      rx_err_q        <= 1'b0;
      tx_busy_q       <= 1'b0;
      last_grant_tx_q <= 1'b0;
      tx_trunc_q      <= 1'b0;
      tx_fin_q        <= 1'b0;
      tx_cnt_q        <= '0;
      rx_len_q        <= '0;
      rx_cnt_q        <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      din_q           <= din_d;
      we_q            <= we_d;
      re_q            <= re_d;
      tx_ready_q      <= tx_ready_d;
      tx_done_q       <= tx_done_d;
      tx_err_q        <= tx_err_d;
      rx_valid_q      <= rx_valid_d;
      rx_last_q       <= rx_last_d;
      rx_byte_q       <= rx_byte_d;
      rx_err_q        <= rx_err_d;
      tx_busy_q       <= tx_busy_d;
      last_grant_tx_q <= last_grant_tx_d;
      tx_trunc_q      <= tx_trunc_d;
      tx_fin_q        <= tx_fin_d;
      tx_cnt_q        <= tx_cnt_d;
      rx_len_q        <= rx_len_d;
      rx_cnt_q        <= rx_cnt_d;
    end
  end

  assign bus.Address     = addr_q;
  assign bus.DataIn      = din_q;
  assign bus.WriteEnable = we_q;
  assign bus.ReadEnable  = re_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.tx_err      = tx_err_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_last     = rx_last_q;
  assign bus.rx_err      = rx_err_q;
endmodule

// File: tb/tb_hdlc_bus_sched.sv
// Scoreboard bench for hdlc_bus_sched with a behavioural HDLC core register model.
// Honours HDLC_BUS_SCHED_WDOG_EN for the Tx watchdog scenario.
module tb_hdlc_bus_sched;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hdlc_bus_sched_if bus();
  hdlc_bus_sched #(.TX_MAX_LEN(126), .TX_TIMEOUT(16)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s timed out", name);
  endtask

  // Scoreboard queues: core writes {addr,data}, Rx beats {last,byte}
  logic [10:0] exp_wr[$];
  logic [8:0]  exp_rx[$];

  // Core model
  logic       tx_done_bit = 1'b1;
  logic       hold_done   = 1'b0;
  int         done_dly    = 5;
  int         done_tmr    = 0;
  logic [7:0] rx_sc_reg   = 8'h00;
  logic [7:0] rx_len_reg  = 8'h00;
  logic [7:0] rx_bytes[0:255];
  int         rx_idx      = 0;
  int         rx_req_id   = 0;
  int         rx_done_id  = 0;
  int         rd_cnt      = 0;
  logic [2:0] rd_log[$];

  assign bus.Rx_Ready = (rx_req_id != rx_done_id);

  always @(posedge Clk) begin
    if (!Rst) begin
      rx_done_id <= rx_req_id;
    end else begin
      if (bus.ReadEnable) begin
        rd_cnt <= rd_cnt + 1;
        rd_log.push_back(bus.Address);
        case (bus.Address)
          3'd0: bus.DataOut <= {7'd0, tx_done_bit};
          3'd2: bus.DataOut <= rx_sc_reg;
          3'd3: begin
            bus.DataOut <= rx_bytes[rx_idx];
            rx_idx      <= rx_idx + 1;
            if (rx_idx + 1 == int'(rx_len_reg)) rx_done_id <= rx_req_id;
          end
          3'd4: begin
            bus.DataOut <= rx_len_reg;
            rx_idx      <= 0;
          end
          default: bus.DataOut <= 8'hEE;
        endcase
      end
      if (bus.WriteEnable) begin
        if (bus.Address == 3'd0 && bus.DataIn[1]) begin
          tx_done_bit <= 1'b0;
          done_tmr    <= done_dly;
        end else if (bus.Address == 3'd0 && bus.DataIn[2]) begin
          tx_done_bit <= 1'b1;
        end else if (bus.Address == 3'd2 && bus.DataIn[1]) begin
          rx_done_id <= rx_req_id;
        end
      end else if (!tx_done_bit && !hold_done) begin
        if (done_tmr == 0) tx_done_bit <= 1'b1;
        else               done_tmr    <= done_tmr - 1;
      end
    end
  end

  // Sink: 0 = stalled, 1 = always ready, 2 = toggling
  int rx_mode = 1;
  always @(posedge Clk) begin
    #1;
    case (rx_mode)
      1:       bus.rx_ready = 1'b1;
      2:       bus.rx_ready = (bus.rx_ready === 1'b1) ? 1'b0 : 1'b1;
      default: bus.rx_ready = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT strobes the core or hands over an Rx byte
  int n_txd = 0, n_txe = 0, n_rxe = 0, n_beats = 0;
  int cyc_start = 0, cyc_abort = 0;
  always @(negedge Clk) begin
    logic [10:0] ew;
    logic [8:0]  er;
    if (Rst === 1'b1) begin
      if (bus.WriteEnable && bus.ReadEnable) begin
        n_checks++;
        n_errs++;
        $display("FAIL strobe_excl WriteEnable and ReadEnable both high at cycle %0d", cyc);
      end
      if (bus.WriteEnable) begin
        if ({bus.Address, bus.DataIn} == 11'h002) cyc_start = cyc;
        if ({bus.Address, bus.DataIn} == 11'h004) cyc_abort = cyc;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_write actual addr=%0d data=%02h required none", bus.Address, bus.DataIn);
        end else begin
          ew = exp_wr.pop_front();
          check("core_write", 32'({bus.Address, bus.DataIn}), 32'(ew));
        end
      end
      if (bus.rx_valid && bus.rx_ready) begin
        n_beats++;
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_rx_beat actual byte=%02h required none", bus.rx_byte);
        end else begin
          er = exp_rx.pop_front();
          check("rx_beat", 32'({bus.rx_last, bus.rx_byte}), 32'(er));
        end
      end
      if (bus.tx_done) n_txd++;
      if (bus.tx_err)  n_txe++;
      if (bus.rx_err)  n_rxe++;
    end
  end

  int n_acc = 0;

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    bus.tx_valid = 1'b1;
    bus.tx_byte  = b;
    bus.tx_last  = last;
    while (bus.tx_ready !== 1'b1 && t < 300) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 300) fail_now("tx_accept");
    else begin
      @(negedge Clk);
      n_acc++;
    end
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
  endtask

  function automatic int evt_val(input int which);
    case (which)
      0:       return n_txd;
      1:       return n_txe;
      2:       return n_rxe;
      3:       return (exp_wr.size() == 0) ? 1 : 0;
      4:       return (exp_rx.size() == 0) ? 1 : 0;
      default: return (bus.rx_valid === 1'b1) ? 1 : 0;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int target, input string name);
    int t;
    t = 0;
    while (evt_val(which) < target && t < 500) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 500) fail_now(name);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.Address, bus.DataIn, bus.WriteEnable, bus.ReadEnable, bus.tx_ready,
                bus.tx_done, bus.tx_err, bus.rx_valid, bus.rx_byte, bus.rx_last, bus.rx_err});
  endfunction

  initial begin
    int b0, r0, e0, a0, l0, gap;
    logic [7:0] f4[4];
    f4[0] = 8'hA5; f4[1] = 8'h01; f4[2] = 8'h02; f4[3] = 8'h03;
    Rst = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_byte  = 8'h00;
    bus.tx_last  = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_outputs", outs(), 32'h0);
    check("reset_state", 32'(dut.state_q), 32'h0);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);

    // 4-byte frame
    for (int i = 0; i < 4; i++) exp_wr.push_back({3'd1, f4[i]});
    exp_wr.push_back({3'd0, 8'h02});
    for (int i = 0; i < 4; i++) send_byte(f4[i], i == 3);
    wait_evt(0, 1, "tx4_done");
    check("tx4_done_cnt", 32'(n_txd), 32'd1);
    check("tx4_err_cnt", 32'(n_txe), 32'd0);
    check("tx4_writes_left", 32'(exp_wr.size()), 32'd0);

    // Rx frame 11,22,33 with a toggling sink
    rx_sc_reg = 8'h00; rx_len_reg = 8'd3;
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
    exp_rx.push_back({1'b0, 8'h11});
    exp_rx.push_back({1'b0, 8'h22});
    exp_rx.push_back({1'b1, 8'h33});
    rx_mode = 2;
    r0 = rd_cnt; b0 = n_beats;
    rx_req_id++;
    wait_evt(4, 1, "rx3_drain");
    repeat (10) @(negedge Clk);
    check("rx3_reads", 32'(rd_cnt - r0), 32'd5);
    check("rx3_beats", 32'(n_beats - b0), 32'd3);
    check("rx3_err_cnt", 32'(n_rxe), 32'd0);

    // Rx frame flagged with a frame error is dropped
    rx_mode = 1;
    rx_sc_reg = 8'h04;
    r0 = rd_cnt; b0 = n_beats;
    exp_wr.push_back({3'd2, 8'h02});
    rx_req_id++;
    wait_evt(2, 1, "rxdrop_err");
    repeat (6) @(negedge Clk);
    check("rxdrop_err_cnt", 32'(n_rxe), 32'd1);
    check("rxdrop_reads", 32'(rd_cnt - r0), 32'd1);
    check("rxdrop_beats", 32'(n_beats - b0), 32'd0);
    check("rxdrop_writes_left", 32'(exp_wr.size()), 32'd0);
    rx_sc_reg = 8'h00;

    // 130-byte frame truncated at 126
    e0 = n_txe; a0 = n_acc; b0 = n_txd;
    for (int i = 0; i < 126; i++) exp_wr.push_back({3'd1, 8'(i)});
    exp_wr.push_back({3'd0, 8'h02});
    for (int i = 0; i < 130; i++) send_byte(8'(i), i == 129);
    wait_evt(0, b0 + 1, "tx130_done");
    check("tx130_accepted", 32'(n_acc - a0), 32'd130);
    check("tx130_err_cnt", 32'(n_txe - e0), 32'd1);
    check("tx130_writes_left", 32'(exp_wr.size()), 32'd0);

    // Tx_Done stuck low
    hold_done = 1'b1;
    e0 = n_txe; b0 = n_txd;
    exp_wr.push_back({3'd1, 8'h3C});
    exp_wr.push_back({3'd0, 8'h02});
`ifdef HDLC_BUS_SCHED_WDOG_EN
    exp_wr.push_back({3'd0, 8'h04});
    send_byte(8'h3C, 1'b1);
    wait_evt(1, e0 + 1, "wdog_err");
    gap = cyc_abort - cyc_start;
    check("wdog_gap_in_range", 32'((gap >= 17 && gap <= 20) ? 1 : 0), 32'd1);
    check("wdog_err_cnt", 32'(n_txe - e0), 32'd1);
    check("wdog_no_done", 32'(n_txd - b0), 32'd0);
    check("wdog_writes_left", 32'(exp_wr.size()), 32'd0);
    hold_done = 1'b0;
`else
    send_byte(8'h3C, 1'b1);
    repeat (100) @(negedge Clk);
    check("nowdog_no_done", 32'(n_txd - b0), 32'd0);
    check("nowdog_no_err", 32'(n_txe - e0), 32'd0);
    check("nowdog_writes_left", 32'(exp_wr.size()), 32'd0);
    hold_done = 1'b0;
    wait_evt(0, b0 + 1, "nowdog_done");
    check("nowdog_done_cnt", 32'(n_txd - b0), 32'd1);
    gap = 0;
`endif
    repeat (5) @(negedge Clk);

    // Rx arrives while Tx is busy, then reset mid-RX_OUT
    hold_done = 1'b1;
    exp_wr.push_back({3'd1, 8'h77});
    exp_wr.push_back({3'd0, 8'h02});
    send_byte(8'h77, 1'b1);
    wait_evt(3, 1, "busy_tx_writes");
    rx_len_reg = 8'd2; rx_bytes[0] = 8'h5A; rx_bytes[1] = 8'h6B;
    rx_mode = 0;
    l0 = rd_log.size();
    rx_req_id++;
    wait_evt(5, 1, "busy_rx_valid");
    if (rd_log.size() >= l0 + 2)
      check("rx_before_poll", 32'((rd_log[l0] == 3'd2 || rd_log[l0+1] == 3'd2) ? 1 : 0), 32'd1);
    else
      fail_now("rx_before_poll_reads");
    check("busy_rx_byte", 32'({bus.rx_valid, bus.rx_last, bus.rx_byte}), 32'h25A);
    repeat (2) @(negedge Clk);
    check("busy_rx_held", 32'({bus.rx_valid, bus.rx_byte}), 32'h15A);
    Rst = 1'b0;
    #1;
    check("midrx_reset_outputs", outs(), 32'h0);
    check("midrx_reset_state", 32'(dut.state_q), 32'h0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    hold_done = 1'b0;
    rx_mode = 1;
    repeat (20) @(negedge Clk);
    check("post_reset_outputs", outs() & 32'h00FFFFFF & ~32'h07F80000, 32'h0);
    check("post_reset_state", 32'(dut.state_q), 32'h0);
    check("post_reset_writes_left", 32'(exp_wr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/hdlc_bus_sched.md
# hdlc_bus_sched

Register-bus scheduler for the HDLC core. It is the sole master of the core's Address/WriteEnable/ReadEnable/DataIn/DataOut bus. It shares that bus between an outgoing-frame byte stream and the draining of received frames: it loads the Tx buffer, starts and supervises transmission, and reads complete Rx frames out to a byte stream. It sits between the system-side frame sources/sinks and the HDLC core.

## Interface
- TX_MAX_LEN, 126: maximum frame bytes loaded into the Tx buffer.
- TX_TIMEOUT, 4096: watchdog limit in cycles for Tx_Done after transmission start (watchdog builds only).
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-low reset.
- tx_valid  in  1  Tx byte offered.
- tx_ready  out  1  Tx byte accepted when tx_valid && tx_ready.
- tx_byte  in  8  frame byte.
- tx_last  in  1  marks the final byte of a frame.
- tx_done  out  1  one-cycle pulse when the core reports the frame was sent.
- tx_err  out  1  one-cycle pulse on truncation or watchdog abort.
- rx_valid  out  1  Rx byte presented.
- rx_ready  in  1  sink accepts when rx_valid && rx_ready.
- rx_byte  out  8  received byte.
- rx_last  out  1  with rx_valid, marks the final byte of a frame.
- rx_err  out  1  one-cycle pulse when a frame is dropped.
- Rx_Ready  in  1  core: complete Rx frame available.
- Address  out  3  core register address.
- WriteEnable  out  1  core write strobe.
- ReadEnable  out  1  core read strobe.
- DataIn  out  8  write data to the core.
- DataOut  in  8  read data from the core, valid the cycle after ReadEnable.

## Operation
- Core register map:
  - 0 Tx_SC: bit0 Tx_Done, bit1 Tx_Enable, bit2 Tx_AbortFrame, bit4 Tx_Full.
  - 1 Tx_Buff.
  - 2 Rx_SC: bit0 Rx_Ready, bit1 Rx_Drop, bit2 Rx_FrameError, bit3 Rx_Abort, bit4 Rx_Overflow.
  - 3 Rx_Buff.
  - 4 Rx_Len.
- States: IDLE, TX_CHK, TX_LOAD, TX_WR, TX_START, TX_POLL, RX_SC, RX_LEN, RX_RD, RX_OUT, RX_DROP.
- Every read is two cycles: ReadEnable for 1 cycle, then DataOut is sampled. Every write is a single-cycle WriteEnable.
- IDLE priority:
  - If tx_busy: Rx_Ready goes to RX_SC; otherwise go to TX_POLL.
  - Else, with Rx_Ready and tx_valid both present, round-robin on the last_grant bit. A lone requester wins immediately.
- Tx path:
  - TX_CHK reads Tx_SC and repeats until Tx_Done=1.
  - TX_LOAD asserts tx_ready. An accepted byte goes to TX_WR, which writes Address=1, DataIn=byte.
  - Byte count is 7 bits. Bytes beyond TX_MAX_LEN are accepted and discarded, and tx_err pulses once at tx_last.
  - After tx_last, TX_START writes Address=0, DataIn=8'h02, sets tx_busy and returns to IDLE.
- TX_POLL reads Tx_SC.
  - Tx_Done=1: clear tx_busy and pulse tx_done.
  - Tx_Done=0: return to IDLE, re-poll next time.
- Rx path:
  - RX_SC reads Rx_SC. Any of bits 2,3,4 set goes to RX_DROP.
  - RX_LEN reads Rx_Len. Len=0 goes to RX_DROP.
  - RX_RD reads Rx_Buff. RX_OUT holds rx_valid with the byte until accepted; rx_last is set on byte Len.
  - After the last accept, return to IDLE.
- RX_DROP writes Address=2, DataIn=8'h02, pulses rx_err and goes to IDLE.

## Timing
- Reset values: state IDLE; all outputs 0 (Address=0, DataIn=0, strobes 0, tx_ready=0, rx_valid=0, pulses 0); tx_busy=0; last_grant=Rx.
- Reset mid-frame aborts immediately. Partially loaded Tx data is left in the core; it is not flushed.
- Strobes are registered, at most one strobe per cycle, never WriteEnable and ReadEnable together.
- Tx throughput: 1 byte per 2 cycles. Rx throughput: 1 byte per 3 cycles with rx_ready held high.
- tx_ready and rx_valid never fall without a completed handshake.
- The Rx byte counter is 8 bits; Len up to 128 is supported.
- Rx_Ready rising mid-Tx-load is serviced only after TX_START. Frame load is atomic.

## Configuration
- HDLC_BUS_SCHED_WDOG_EN defined:
  - A 16-bit counter runs while tx_busy.
  - When it reaches TX_TIMEOUT, the block writes Address=0, DataIn=8'h04 (Tx_AbortFrame), clears tx_busy and pulses tx_err.
- Undefined: no counter; tx_busy clears only on Tx_Done=1.

## Test plan
- 4-byte frame 8'hA5,01,02,03 with Tx idle -> four writes to address 1 in order, then 8'h02 written to address 0; tx_done pulses after the model sets Tx_Done.
- Model Rx_Ready=1, Rx_SC=0, Rx_Len=3, bytes 11,22,33 with rx_ready toggling -> three rx_valid beats, rx_last on 33, exactly 5 reads.
- Rx_SC=8'h04 -> single write of 8'h02 to address 2, rx_err pulse, no rx_valid.
- 130-byte frame with TX_MAX_LEN=126 -> 126 Tx_Buff writes, all 130 accepted, tx_err pulse, Tx_Enable still written.
- Tx_Done held 0 with WDOG_EN and TX_TIMEOUT=16 -> 8'h04 written to address 0 after 16 busy cycles, tx_err pulse; without the macro, no abort.
- Rx_Ready arriving with tx_busy set, plus reset asserted mid-RX_OUT -> Rx serviced before the next poll; after reset all outputs are 0 and the state is IDLE.
